aes_result_collector: RTL and testbench
=======================================

# aes_result_collector

Downstream neighbour of the AES test transactor: it consumes the encoder/decoder outputs, checks them against expected values aligned through a NUM_ROUNDS delay line, and packs each checked result into a record. Records are buffered in a FIFO and drained over a valid/ready handshake toward the SCE-MI output pipe. An end-of-test flush sequence lets the HVL side know when every in-flight result has been delivered.

## Interface
Parameters:
- NUM_ROUNDS, 10: pipeline depth of encoder/decoder; delay-line length.
- FIFO_DEPTH, 16: record buffer entries; power of two, at least 2.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- encryptIn  in  128  encoder output (state_t).
- encryptValid  in  1  encoder output valid.
- plainIn  in  128  decoder output (state_t).
- plainValid  in  1  decoder output valid.
- expEncrypt  in  128  expected ciphertext, presented with the corresponding stimulus.
- expPlain  in  128  expected plaintext, presented with the stimulus.
- expValid  in  1  expected pair valid.
- flush  in  1  end-of-stimulus pulse.
- outRecord  out  result_t  head-of-FIFO record.
- outValid  out  1  outRecord valid.
- outReady  in  1  consumer accepts outRecord.
- passCount  out  32  records with no mismatch; saturating.
- failCount  out  32  records with at least one mismatch; saturating.
- overflow  out  1  sticky; a record was dropped because the FIFO was full.
- done  out  1  flush complete and FIFO empty.

## Operation
- Delay line: NUM_ROUNDS-deep shift of {expValid, expEncrypt, expPlain}. An entry pushed in cycle M is aligned with the outputs of cycle M+NUM_ROUNDS.
- Capture happens in any cycle where encryptValid or plainValid is high.
- Record fields:
  - seq[15:0]: capture counter; wraps 0xFFFF to 0.
  - encrypt and plain: captured data.
  - encValid and decValid: the input valids.
  - encMatch = encryptValid & alignedExpValid & (encryptIn == alignedExpEncrypt). decMatch is defined the same way for the plain side.
  - unexpected = capture & !alignedExpValid.
- Pass means every asserted valid has its match set and unexpected is 0. Anything else is a fail.
- Count update: exactly one of passCount or failCount increments per captured record, at FIFO-write time, even if the record is dropped.
- FIFO: read/write pointers are log2(FIFO_DEPTH)+1 bits wide; the extra bit marks wrap.
  - Full: write into a full FIFO without a same-cycle pop drops the record and sets overflow.
  - Push and pop in the same cycle while full are both accepted.
  - Empty: outValid=0 and outRecord holds its last value.
- FSM:
  - RUN: on flush, load a drain counter with NUM_ROUNDS+1 and go to FLUSH.
  - FLUSH: decrement the counter each cycle; captures continue. At 0, go to DRAIN.
  - DRAIN: when the FIFO is empty and the compare stage is idle, go to DONE.
  - DONE: done=1 and stays there until reset. Captures in DONE are still recorded; done does not drop.
  - flush asserted outside RUN is ignored.
- Reset mid-operation: FIFO emptied, delay-line valids cleared, compare stage invalidated, state returns to RUN. Data contents are don't-care.

## Timing
- Reset values: outValid=0, outRecord=0, passCount=0, failCount=0, overflow=0, done=0, seq=0, state RUN.
- Capture in cycle N: the compare stage registers at the end of N, and the FIFO write happens at the end of N+1.
- Latency: if the FIFO is empty, outValid=1 in cycle N+2. Capture-to-outValid latency is 2 cycles.
- Counters change at the FIFO-write edge, i.e. they are visible in cycle N+2.
- Handshake: a transfer occurs on a clock edge with outValid & outReady. outRecord is stable while outValid & !outReady. The next record is presented the following cycle.
- Throughput: one capture per cycle sustained when outReady=1.
- done rises at most 1 cycle after the last pop once in DRAIN.

## Structure
- Shared package AESTestDefinitions holds the result_t typedef, the collector FSM state enum, and the SEQ_WIDTH=16 constant. It uses state_t from AESDefinitions.
- The FIFO is a separate sub-module, ResultFifo #(type T, DEPTH), with push/pop/full/empty ports. It is reusable for the input side.
- The delay line reuses the existing Buffer cell, chained NUM_ROUNDS times.

## Test plan
- Directed match: push expEncrypt=0x3925841D02DC09FBDC118597196A0B32, then raise encryptValid with that same value NUM_ROUNDS cycles later. Required: record seq=0, encMatch=1, passCount=1, outValid in cycle +2.
- Mismatch: same as above but flip bit 0 of encryptIn. Required: encMatch=0, failCount=1, passCount=0.
- Unexpected output: encryptValid=1 with no expValid pushed 10 cycles earlier. Required: unexpected=1, failCount=1.
- Backpressure/overflow: outReady=0 for 20 consecutive captures with FIFO_DEPTH=16. Required: records seq 0..15 are retained, overflow=1, and the counters total 20. Then outReady=1 drains seq 0..15 in order.
- Full with simultaneous push/pop: FIFO full, one capture and outReady=1 in the same cycle. Required: no drop, overflow remains 0, occupancy stays 16.
- Flush and reset: flush, then after NUM_ROUNDS+1 cycles plus the drain, done=1. Reset asserted during FLUSH returns state to RUN with done=0, outValid=0 and counters=0 on the next cycle.

Source files
------------

// File: rtl/aes_result_collector_pkg.sv
// AESDefinitions: AES datapath types shared by the encoder, decoder and test logic.
// AESTestDefinitions: result record, expected-value entry and collector FSM state
// used by aes_result_collector and its bench.
package AESDefinitions;
   typedef logic [127:0] state_t;
endpackage

package AESTestDefinitions;
   import AESDefinitions::*;

   localparam int unsigned SEQ_WIDTH = 16;

   // One checked result as delivered toward the output pipe.
   typedef struct packed {
      logic [SEQ_WIDTH-1:0] seq;
      state_t               encrypt;
      state_t               plain;
      logic                 encValid;
      logic                 decValid;
      logic                 encMatch;
      logic                 decMatch;
      logic                 unexpected;
   } result_t;

   // Expected ciphertext/plaintext pair carried down the delay line.
   typedef struct packed {
      state_t expEncrypt;
      state_t expPlain;
   } expected_t;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DRAIN,
      DONE
   } collectorState_t;

   // A record passes when every reported output matched and it was expected.
   function automatic logic isPass(input result_t r);
      return (!r.encValid || r.encMatch) && (!r.decValid || r.decMatch) && !r.unexpected;
   endfunction
endpackage

// File: rtl/aes_result_collector_buffer.sv
// Buffer: one register stage of a valid/data pipe. Only the valid is reset.
//   clock, reset       : clock and synchronous active-high reset
//   inValid, inData    : stage input
//   outValid, outData  : stage output, one cycle later
module Buffer #(
   parameter type T = logic
) (
   input  logic clock,
   input  logic reset,
   input  logic inValid,
   input  T     inData,
   output logic outValid,
   output T     outData
);

   always_ff @(posedge clock) begin
      if (reset) outValid <= 1'b0;
      else       outValid <= inValid;
   end

   always_ff @(posedge clock) begin
      outData <= inData;
   end

endmodule

// File: rtl/aes_result_collector_fifo.sv
// ResultFifo: synchronous FIFO with pointers one bit wider than the address so
// full and empty are distinguished by the wrap bit.
//   clock, reset      : clock and synchronous active-high reset (empties the FIFO)
//   push, pushData    : write request; dropped when full unless popping same cycle
//   pop, popData      : read request and current head entry
//   full, empty       : occupancy flags
module ResultFifo #(
   parameter type         T     = logic,
   parameter int unsigned DEPTH = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  T     pushData,
   input  logic pop,
   output T     popData,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   T              mem [DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic          doWrite;
   logic          doRead;

   assign empty   = (wrPtr == rdPtr);
   assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doRead  = pop && !empty;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
   assign doWrite = push && (!full || doRead);
   assign popData = mem[rdPtr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doWrite) wrPtr <= wrPtr + PW'(1);
         if (doRead)  rdPtr <= rdPtr + PW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (doWrite) mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/aes_result_collector.sv
// aes_result_collector: checks encoder/decoder outputs against expected values
// delayed NUM_ROUNDS cycles, packs each capture into a result record, buffers the
// records and drains them over valid/ready. A flush sequence raises done once all
// in-flight results have been delivered.
//   clock, reset                          : clock, synchronous active-high reset
//   encryptIn/encryptValid, plainIn/plainValid : encoder/decoder outputs
//   expEncrypt, expPlain, expValid        : expected pair, presented with stimulus
//   flush                                 : end-of-stimulus pulse
//   outRecord, outValid, outReady         : record output handshake
//   passCount, failCount                  : saturating record tallies
//   overflow                              : sticky, a record was dropped
//   done                                  : flush complete and FIFO empty
module aes_result_collector
   import AESDefinitions::*, AESTestDefinitions::*;
#(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  state_t      encryptIn,
   input  logic        encryptValid,
   input  state_t      plainIn,
   input  logic        plainValid,
   input  state_t      expEncrypt,
   input  state_t      expPlain,
   input  logic        expValid,
   input  logic        flush,
   output result_t     outRecord,
   output logic        outValid,
   input  logic        outReady,
   output logic [31:0] passCount,
   output logic [31:0] failCount,
   output logic        overflow,
   output logic        done
);

   localparam int unsigned CNT_W = $clog2(NUM_ROUNDS + 2);

   // Expected-value delay line: stage NUM_ROUNDS lines up with the current outputs.
   logic      dlValid [NUM_ROUNDS+1];
   expected_t dlData  [NUM_ROUNDS+1];

   assign dlValid[0] = expValid;
   assign dlData[0]  = {expEncrypt, expPlain};

   for (genvar i = 0; i < NUM_ROUNDS; i++) begin : gDelay
      Buffer #(.T(expected_t)) uStage (
         .clock   (clock),
         .reset   (reset),
         .inValid (dlValid[i]),
         .inData  (dlData[i]),
         .outValid(dlValid[i+1]),
         .outData (dlData[i+1])
      );
   end

   // Compare stage: build the record combinationally, register it on capture.
   logic                 capture;
   logic                 alignedValid;
   expected_t            aligned;
   result_t              captRecord;
   result_t              cmpRecord;
   logic                 cmpValid;
   logic [SEQ_WIDTH-1:0] seqCnt;

   assign capture      = encryptValid | plainValid;
   assign alignedValid = dlValid[NUM_ROUNDS];
   assign aligned      = dlData[NUM_ROUNDS];

   always_comb begin
      captRecord            = '0;
      captRecord.seq        = seqCnt;
      captRecord.encrypt    = encryptIn;
      captRecord.plain      = plainIn;
      captRecord.encValid   = encryptValid;
      captRecord.decValid   = plainValid;
      captRecord.encMatch   = encryptValid & alignedValid & (encryptIn == aligned.expEncrypt);
      captRecord.decMatch   = plainValid & alignedValid & (plainIn == aligned.expPlain);
      captRecord.unexpected = capture & ~alignedValid;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cmpValid <= 1'b0;
         seqCnt   <= '0;
      end else begin
         cmpValid <= capture;
         if (capture) seqCnt <= seqCnt + SEQ_WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (capture) cmpRecord <= captRecord;
   end

   // Record buffer and output handshake.
   logic    fifoFull;
   logic    fifoEmpty;
   logic    fifoPop;
   result_t headRecord;
   result_t lastRecord;

   assign fifoPop = outReady & ~fifoEmpty;

   ResultFifo #(.T(result_t), .DEPTH(FIFO_DEPTH)) uFifo (
      .clock   (clock),
      .reset   (reset),
      .push    (cmpValid),
      .pushData(cmpRecord),
      .pop     (fifoPop),
      .popData (headRecord),
      .full    (fifoFull),
      .empty   (fifoEmpty)
   );

   // When empty, keep showing the record most recently handed over.
   always_ff @(posedge clock) begin
      if (reset)        lastRecord <= '0;
      else if (fifoPop) lastRecord <= headRecord;
   end

   assign outValid  = ~fifoEmpty;
   assign outRecord = fifoEmpty ? lastRecord : headRecord;

   // Tallies count every compared record, including ones dropped on overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         passCount <= '0;
         failCount <= '0;
         overflow  <= 1'b0;
      end else begin
         if (cmpValid) begin
            if (isPass(cmpRecord)) begin
               if (passCount != '1) passCount <= passCount + 32'd1;
            end else if (failCount != '1) begin
               failCount <= failCount + 32'd1;
            end
         end
         if (cmpValid && fifoFull && !fifoPop) overflow <= 1'b1;
      end
   end

   // End-of-test FSM: wait out the pipeline, then the buffer, then report done.
   collectorState_t  state;
   collectorState_t  stateNext;
   logic [CNT_W-1:0] drainCnt;
   logic [CNT_W-1:0] drainCntNext;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= RUN;
         drainCnt <= '0;
      end else begin
         state    <= stateNext;
         drainCnt <= drainCntNext;
      end
   end

   always_comb begin
      stateNext    = state;
      drainCntNext = drainCnt;
      case (state)
         RUN: begin
            if (flush) begin
               stateNext    = FLUSH;
               drainCntNext = CNT_W'(NUM_ROUNDS + 1);
            end
         end
         FLUSH: begin
            if (drainCnt == '0) stateNext = DRAIN;
            else                drainCntNext = drainCnt - CNT_W'(1);
         end
         DRAIN: begin
            if (fifoEmpty && !cmpValid) stateNext = DONE;
         end
         DONE:    stateNext = DONE;
         default: stateNext = RUN;
      endcase
   end

   assign done = (state == DONE);

endmodule

// File: tb/tb_aes_result_collector.sv
// Directed bench for aes_result_collector with a record scoreboard and monitor.
module tb_aes_result_collector;
   import AESDefinitions::*;
   import AESTestDefinitions::*;

   localparam state_t K  = 128'h3925841D02DC09FBDC118597196A0B32;
   localparam state_t P  = 128'h3243F6A8885A308D313198A2E0370734;
   localparam state_t K2 = 128'h00112233445566778899AABBCCDDEEFF;
   localparam state_t P2 = 128'h000102030405060708090A0B0C0D0E0F;

   logic        clock;
   logic        reset;
   state_t      encryptIn;
   logic        encryptValid;
   state_t      plainIn;
   logic        plainValid;
   state_t      expEncrypt;
   state_t      expPlain;
   logic        expValid;
   logic        flush;
   result_t     outRecord;
   logic        outValid;
   logic        outReady;
   logic [31:0] passCount;
   logic [31:0] failCount;
   logic        overflow;
   logic        done;

   int            checks = 0;
   int            errors = 0;
   int            popCount = 0;
   logic [15:0]   tbSeq = '0;
   result_t       sbQ[$];

   aes_result_collector #(.NUM_ROUNDS(10), .FIFO_DEPTH(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .encryptIn   (encryptIn),
      .encryptValid(encryptValid),
      .plainIn     (plainIn),
      .plainValid  (plainValid),
      .expEncrypt  (expEncrypt),
      .expPlain    (expPlain),
      .expValid    (expValid),
      .flush       (flush),
      .outRecord   (outRecord),
      .outValid    (outValid),
      .outReady    (outReady),
      .passCount   (passCount),
      .failCount   (failCount),
      .overflow    (overflow),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic doReset();
      reset        = 1'b1;
      encryptValid = 1'b0;
      plainValid   = 1'b0;
      expValid     = 1'b0;
      flush        = 1'b0;
      sbQ.delete();
      tbSeq = '0;
      step(1);
      reset = 1'b0;
   endtask

   task automatic pushExp(input state_t e, input state_t p);
      expValid   = 1'b1;
      expEncrypt = e;
      expPlain   = p;
      step(1);
      expValid = 1'b0;
   endtask

   // Drive one capture cycle and queue its hand-derived expected record.
   task automatic capture(input logic eV, input state_t e, input logic dV, input state_t d,
                          input logic eM, input logic dM, input logic unexp, input logic keep);
      result_t r;
      r.seq        = tbSeq;
      r.encrypt    = e;
      r.plain      = d;
      r.encValid   = eV;
      r.decValid   = dV;
      r.encMatch   = eM;
      r.decMatch   = dM;
      r.unexpected = unexp;
      if (keep) sbQ.push_back(r);
      tbSeq++;
      encryptValid = eV;
      encryptIn    = e;
      plainValid   = dV;
      plainIn      = d;
      step(1);
      encryptValid = 1'b0;
      plainValid   = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while (sbQ.size() != 0 && n < 100) begin
         step(1);
         n++;
      end
      chk(name, 32'(sbQ.size()), 32'd0);
   endtask

   // Monitor: every accepted record is compared with the head of the scoreboard.
   initial begin
      result_t expRec;
      forever begin
         @(negedge clock);
         if (!reset && outValid && outReady) begin
            checks++;
            if (sbQ.size() == 0) begin
               errors++;
               $display("FAIL extra_record: got seq=%0h required no record", outRecord.seq);
            end else begin
               expRec = sbQ.pop_front();
               popCount++;
               if (outRecord !== expRec) begin
                  errors++;
                  $display("FAIL record: got seq=%0h enc=%h pl=%h flags=%b required seq=%0h enc=%h pl=%h flags=%b",
                     outRecord.seq, outRecord.encrypt, outRecord.plain,
                     {outRecord.encValid, outRecord.decValid, outRecord.encMatch, outRecord.decMatch, outRecord.unexpected},
                     expRec.seq, expRec.encrypt, expRec.plain,
                     {expRec.encValid, expRec.decValid, expRec.encMatch, expRec.decMatch, expRec.unexpected});
               end
            end
         end
      end
   end

   initial begin
      int n;
      reset        = 1'b1;
      encryptIn    = '0;
      encryptValid = 1'b0;
      plainIn      = '0;
      plainValid   = 1'b0;
      expEncrypt   = '0;
      expPlain     = '0;
      expValid     = 1'b0;
      flush        = 1'b0;
      outReady     = 1'b1;
      step(2);
      reset = 1'b0;

      // Reset values
      chk("rst_outValid", 32'(outValid), 32'd0);
      chk("rst_outRecord_zero", 32'(outRecord != '0), 32'd0);
      chk("rst_passCount", passCount, 32'd0);
      chk("rst_failCount", failCount, 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Directed match with latency
      doReset();
      pushExp(K, P);
      step(9);
      capture(1'b1, K, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("match_outValid_n1", 32'(outValid), 32'd0);
      step(1);
      chk("match_outValid_n2", 32'(outValid), 32'd1);
      chk("match_passCount", passCount, 32'd1);
      chk("match_failCount", failCount, 32'd0);
      waitDrain("match_drain");

      // Mismatch on bit 0
      doReset();
      pushExp(K, P);
      step(9);
      capture(1'b1, K ^ 128'h1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1);
      chk("mismatch_failCount", failCount, 32'd1);
      chk("mismatch_passCount", passCount, 32'd0);
      waitDrain("mismatch_drain");

      // Unexpected output
      doReset();
      step(12);
      capture(1'b1, K2, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1);
      chk("unexp_failCount", failCount, 32'd1);
      waitDrain("unexp_drain");

      // Alignment edge: one cycle early is unexpected, exactly NUM_ROUNDS matches
      doReset();
      pushExp(K, P);
      step(8);
      capture(1'b1, K, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      capture(1'b1, K, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1);
      chk("align_passCount", passCount, 32'd1);
      chk("align_failCount", failCount, 32'd1);
      waitDrain("align_drain");

      // Both sides: back-to-back pairs, second has a decoder mismatch
      doReset();
      pushExp(K, P);
      pushExp(K2, P2);
      step(8);
      capture(1'b1, K, 1'b1, P, 1'b1, 1'b1, 1'b0, 1'b1);
      capture(1'b1, K2, 1'b1, P2 ^ 128'h80, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1);
      chk("both_passCount", passCount, 32'd1);
      chk("both_failCount", failCount, 32'd1);
      waitDrain("both_drain");

      // Backpressure and overflow: 20 captures into 16 entries
      doReset();
      outReady = 1'b0;
      for (int i = 0; i < 20; i++)
         capture(1'b1, 128'(i), 1'b0, '0, 1'b0, 1'b0, 1'b1, (i < 16) ? 1'b1 : 1'b0);
      step(2);
      chk("bp_overflow", 32'(overflow), 32'd1);
      chk("bp_total", passCount + failCount, 32'd20);
      chk("bp_head_seq", 32'(outRecord.seq), 32'd0);
      outReady = 1'b1;
      waitDrain("bp_drain");
      chk("bp_empty_outValid", 32'(outValid), 32'd0);
      chk("bp_hold_seq", 32'(outRecord.seq), 32'd15);
      chk("bp_overflow_sticky", 32'(overflow), 32'd1);

      // Full FIFO with simultaneous push and pop
      doReset();
      outReady = 1'b0;
      for (int i = 0; i < 16; i++)
         capture(1'b1, 128'(i), 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(2);
      chk("full_overflow_pre", 32'(overflow), 32'd0);
      capture(1'b1, 128'h16, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      outReady = 1'b1;
      step(1);
      outReady = 1'b0;
      chk("full_pushpop_overflow", 32'(overflow), 32'd0);
      capture(1'b1, 128'h17, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(2);
      chk("full_still_full_overflow", 32'(overflow), 32'd1);
      chk("full_failCount", failCount, 32'd18);
      popCount = 0;
      outReady = 1'b1;
      waitDrain("full_drain");
      chk("full_occupancy", 32'(popCount), 32'd16);

      // Flush, captures during FLUSH and DONE
      doReset();
      outReady = 1'b1;
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      step(2);
      capture(1'b1, K, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      n = 4;
      while (!done && n < 40) begin
         step(1);
         n++;
      end
      chk("flush_done_cycle", 32'(n), 32'd14);
      chk("flush_failCount", failCount, 32'd1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      capture(1'b1, K2, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(2);
      chk("done_sticky", 32'(done), 32'd1);
      chk("done_capture_count", failCount, 32'd2);
      waitDrain("done_drain");

      // Reset during FLUSH
      doReset();
      outReady = 1'b0;
      for (int i = 0; i < 3; i++)
         capture(1'b1, 128'(i), 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      step(2);
      chk("pre_reset_failCount", failCount, 32'd3);
      doReset();
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_outValid", 32'(outValid), 32'd0);
      chk("midrst_passCount", passCount, 32'd0);
      chk("midrst_failCount", failCount, 32'd0);
      chk("midrst_outRecord_zero", 32'(outRecord != '0), 32'd0);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      n = 1;
      while (!done && n < 40) begin
         step(1);
         n++;
      end
      chk("midrst_refl_done_cycle", 32'(n), 32'd14);

      step(2);
      chk("scoreboard_empty", 32'(sbQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
